freq_meter_50m: RTL

FREQ_METER_50M -- requirements
Module: freq_meter_50m

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/freq_meter_50m_sync_edge_det.sv | 30 +++
 rtl/freq_meter_50m.sv | 129 ++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and default sizing for the freq_meter_50m period meter.
`timescale 1ns/1ps
package freq_meter_pkg;

    localparam int CNT_W_DEF       = 24;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } fm_state_e;

endpackage

// File: rtl/freq_meter_50m_sync_edge_det.sv
// Metastability synchronizer for an asynchronous input followed by a
// rising-edge detector; rise is high for one cycle per synchronized 0->1.
`timescale 1ns/1ps
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/freq_meter_50m.sv
// Period meter: counts clk_in cycles between rising edges of sig_in.
// Define FREQ_METER_AVG4_EN to average four consecutive periods.
`timescale 1ns/1ps
module freq_meter_50m
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             busy,
    output logic             timeout
);

    // A counter at this value with no edge would saturate on the next cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    logic             rise;
    fm_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             busy_q;
    logic             timeout_q;

`ifdef FREQ_METER_AVG4_EN
    logic [CNT_W+1:0] acc_q;
    logic [1:0]       idx_q;
    logic [CNT_W+1:0] acc_sum;
    assign acc_sum = acc_q + {2'b00, cnt_q};
`endif

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in(clk_in),
        .rst   (rst),
        .d     (sig_in),
        .rise  (rise)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef FREQ_METER_AVG4_EN
            acc_q     <= '0;
            idx_q     <= '0;
`endif
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ARM;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state_q <= MEASURE;
                        cnt_q   <= CNT_W'(1);
`ifdef FREQ_METER_AVG4_EN
                        acc_q   <= '0;
                        idx_q   <= '0;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        cnt_q     <= cnt_q + 1'b1;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MEASURE: begin
                    // An edge wins over saturation in the same cycle.
                    if (rise) begin
`ifdef FREQ_METER_AVG4_EN
                        if (idx_q == 2'd3) begin
                            state_q  <= IDLE;
                            period_q <= acc_sum[CNT_W+1:2];
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            acc_q <= acc_sum;
                            idx_q <= idx_q + 1'b1;
                            cnt_q <= CNT_W'(1);
                        end
`else
                        state_q  <= IDLE;
                        period_q <= cnt_q;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        cnt_q     <= cnt_q + 1'b1;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign busy         = busy_q;
    assign timeout      = timeout_q;

endmodule
